bench_sequencer: RTL and testbench

Sequencer for the radix/router benchmark engine. It runs the four benchmark conditions in order: cond0 all base2, cond1 all base10, cond2 all base12, cond3 router. For each condition it issues a fixed number of jobs to the external job datapath over a start/done handshake and measures each condition's cycle count. It then selects the fastest condition and drives the one-hot LED result consumed by the board top level.

---
 rtl/bench_pkg.sv | 23 ++
 rtl/sat_counter.sv | 25 ++
 rtl/bench_sequencer.sv | 167 ++++++++++++++++
 tb/tb_bench_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bench_pkg.sv
// Shared types and constants for the radix/router benchmark sequencer.
package bench_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam int NUM_COND = 4;

  localparam logic [1:0] COND_BASE2  = 2'd0;
  localparam logic [1:0] COND_BASE10 = 2'd1;
  localparam logic [1:0] COND_BASE12 = 2'd2;
  localparam logic [1:0] COND_ROUTER = 2'd3;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] TIMER_MAX = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear, enable and force-to-max controls.
module sat_counter
  import bench_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             force_max,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (force_max) begin
      count <= '1;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bench_sequencer.sv
// Runs the four benchmark conditions, times each one and reports the fastest
// on a one-hot LED vector.
module bench_sequencer
  import bench_pkg::*;
#(
  parameter int NUM_COND      = bench_pkg::NUM_COND,
  parameter int JOBS_PER_COND = 256,
  parameter int TIMEOUT       = 1048576,
  parameter int CNT_W         = bench_pkg::CNT_W
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             start,
  output logic             job_start,
  output logic [1:0]       cond_sel,
  output logic [15:0]      job_id,
  input  logic             job_done,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] t_cond0,
  output logic [CNT_W-1:0] t_cond1,
  output logic [CNT_W-1:0] t_cond2,
  output logic [CNT_W-1:0] t_cond3,
  output logic [3:0]       timeout_flag,
  output logic [3:0]       led_onehot
);

  state_t state, state_next;

  logic [CNT_W-1:0] timer [NUM_COND];
  logic [CNT_W-1:0] wait_cnt;

  logic [1:0]       scan_idx;
  logic             best_found;
  logic [1:0]       best_idx;
  logic [CNT_W-1:0] best_val;

  logic clear_results;
  logic timing;
  logic last_job;
  logic timed_out;
  logic cand_take;
  logic win_found;
  logic [1:0] win_idx;

  assign clear_results = (state == S_IDLE) || ((state == S_DONE) && start);
  assign timing        = (state == S_ISSUE) || (state == S_WAIT);
  assign last_job      = (job_id == 16'(JOBS_PER_COND - 1));
  // A real job_done on the final WAIT cycle wins over the abort.
  assign timed_out     = (state == S_WAIT) && !job_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Argmin step for the condition currently under the scan pointer.
  assign cand_take = !timeout_flag[scan_idx] && (!best_found || (timer[scan_idx] < best_val));
  assign win_found = best_found || cand_take;
  assign win_idx   = cand_take ? scan_idx : best_idx;

  generate
    for (genvar gi = 0; gi < NUM_COND; gi++) begin : g_timer
      sat_counter #(.WIDTH(CNT_W)) u_timer (
        .clk       (sysclk),
        .rst       (rst),
        .clr       (clear_results),
        .en        (timing && (cond_sel == 2'(gi))),
        .force_max (timed_out && (cond_sel == 2'(gi))),
        .count     (timer[gi])
      );
    end
  endgenerate

  sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk       (sysclk),
    .rst       (rst),
    .clr       (state != S_WAIT),
    .en        (state == S_WAIT),
    .force_max (1'b0),
    .count     (wait_cnt)
  );

  assign t_cond0 = timer[0];
  assign t_cond1 = timer[1];
  assign t_cond2 = timer[2];
  assign t_cond3 = timer[3];

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT: begin
        if (job_done)       state_next = last_job ? S_NEXT : S_ISSUE;
        else if (timed_out) state_next = S_NEXT;
      end
      S_NEXT:    state_next = (cond_sel == COND_ROUTER) ? S_COMPARE : S_ISSUE;
      S_COMPARE: if (scan_idx == 2'd3) state_next = S_DONE;
      S_DONE:    if (start) state_next = S_ISSUE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      job_start    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cond_sel     <= COND_BASE2;
      job_id       <= '0;
      timeout_flag <= '0;
      led_onehot   <= '0;
      scan_idx     <= '0;
      best_found   <= 1'b0;
      best_idx     <= '0;
      best_val     <= '0;
    end else begin
      job_start <= (state_next == S_ISSUE);
      busy      <= (state_next == S_ISSUE) || (state_next == S_WAIT) ||
                   (state_next == S_NEXT)  || (state_next == S_COMPARE);
      done      <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          cond_sel     <= COND_BASE2;
          job_id       <= '0;
          timeout_flag <= '0;
          led_onehot   <= '0;
        end
        S_WAIT: begin
          if (job_done && !last_job) job_id <= job_id + 16'd1;
          else if (timed_out)        timeout_flag[cond_sel] <= 1'b1;
        end
        S_NEXT: begin
          if (cond_sel != COND_ROUTER) begin
            cond_sel <= cond_sel + 2'd1;
            job_id   <= '0;
          end
          scan_idx   <= '0;
          best_found <= 1'b0;
          best_idx   <= '0;
          best_val   <= '0;
        end
        S_COMPARE: begin
          scan_idx   <= scan_idx + 2'd1;
          best_found <= win_found;
          best_idx   <= win_idx;
          if (cand_take) best_val <= timer[scan_idx];
          if (scan_idx == 2'd3) led_onehot <= win_found ? (4'b0001 << win_idx) : 4'b0000;
        end
        S_DONE: begin
          if (start) begin
            cond_sel     <= COND_BASE2;
            job_id       <= '0;
            timeout_flag <= '0;
            led_onehot   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bench_sequencer.sv
// Directed bench for bench_sequencer with a latency-programmable job responder.
module tb_bench_sequencer;
  import bench_pkg::*;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        start;
  logic        job_start;
  logic [1:0]  cond_sel;
  logic [15:0] job_id;
  logic        job_done;
  logic        busy;
  logic        done;
  logic [31:0] t_cond0, t_cond1, t_cond2, t_cond3;
  logic [3:0]  timeout_flag;
  logic [3:0]  led_onehot;

  int tests = 0;
  int fails = 0;
  int lat [4];
  int last_done_iter;
  int done_iter;
  logic done_seen;

  always #5 sysclk = ~sysclk;

  bench_sequencer #(.JOBS_PER_COND(4), .TIMEOUT(16)) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .start        (start),
    .job_start    (job_start),
    .cond_sel     (cond_sel),
    .job_id       (job_id),
    .job_done     (job_done),
    .busy         (busy),
    .done         (done),
    .t_cond0      (t_cond0),
    .t_cond1      (t_cond1),
    .t_cond2      (t_cond2),
    .t_cond3      (t_cond3),
    .timeout_flag (timeout_flag),
    .led_onehot   (led_onehot)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(negedge sysclk) start = 1'b1;
    @(negedge sysclk) start = 1'b0;
  endtask

  // Responds to each job_start after lat[cond_sel] cycles (0 = never).
  // spur injects start/job_done during an ISSUE cycle; stop_cond >= 0 stops
  // one cycle after that condition's first job_start (i.e. inside WAIT).
  task automatic run(input int spur, input int stop_cond);
    int pending = 0;
    int cnt = 0;
    int stop_next = 0;
    done_seen = 1'b0;
    last_done_iter = -1;
    done_iter = -1;
    for (int i = 0; i < 2000; i++) begin
      if (stop_next != 0) return;
      if (done) begin
        done_seen = 1'b1;
        done_iter = i;
        return;
      end
      if (pending != 0) begin
        cnt--;
        if (cnt == 0) begin
          job_done = 1'b1;
          pending = 0;
          last_done_iter = i;
        end
      end else if (job_start) begin
        if (lat[cond_sel] > 0) begin
          pending = 1;
          cnt = lat[cond_sel];
        end
        if (spur != 0 && cond_sel == 2'd1 && job_id == 16'd1) begin
          job_done = 1'b1;
          start = 1'b1;
        end
        if (stop_cond >= 0 && int'(cond_sel) == stop_cond) stop_next = 1;
      end
      @(negedge sysclk);
      job_done = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    job_done = 1'b0;
    repeat (3) @(negedge sysclk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_job_start", 32'(job_start), 32'd0);
    check("reset_t0", t_cond0, 32'd0);
    check("reset_led", 32'(led_onehot), 32'd0);
    rst = 1'b0;

    // Basic ranking
    lat[0] = 3; lat[1] = 5; lat[2] = 2; lat[3] = 4;
    pulse_start();
    check("basic_job_start_latency", 32'(job_start), 32'd1);
    check("basic_busy", 32'(busy), 32'd1);
    run(0, -1);
    check("basic_done_seen", 32'(done_seen), 32'd1);
    check("basic_done_delay", 32'(done_iter - last_done_iter), 32'd6);
    check("basic_total_cycles", 32'(done_iter), 32'd80);
    check("basic_t0", t_cond0, 32'd16);
    check("basic_t1", t_cond1, 32'd24);
    check("basic_t2", t_cond2, 32'd12);
    check("basic_t3", t_cond3, 32'd20);
    check("basic_led", 32'(led_onehot), 32'b0100);
    check("basic_tflag", 32'(timeout_flag), 32'd0);
    check("basic_busy_done", 32'(busy), 32'd0);

    // Restart from DONE with spurious start/job_done while busy
    pulse_start();
    check("restart_t0_clr", t_cond0, 32'd0);
    check("restart_t1_clr", t_cond1, 32'd0);
    check("restart_t3_clr", t_cond3, 32'd0);
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_led_clr", 32'(led_onehot), 32'd0);
    run(1, -1);
    check("restart_done_seen", 32'(done_seen), 32'd1);
    check("restart_t0", t_cond0, 32'd16);
    check("restart_t1", t_cond1, 32'd24);
    check("restart_t2", t_cond2, 32'd12);
    check("restart_t3", t_cond3, 32'd20);
    check("restart_led", 32'(led_onehot), 32'b0100);

    // Tie-break
    lat[0] = 2; lat[1] = 2; lat[2] = 2; lat[3] = 2;
    pulse_start();
    run(0, -1);
    check("tie_done_seen", 32'(done_seen), 32'd1);
    check("tie_t0", t_cond0, 32'd12);
    check("tie_t1", t_cond1, 32'd12);
    check("tie_t2", t_cond2, 32'd12);
    check("tie_t3", t_cond3, 32'd12);
    check("tie_led", 32'(led_onehot), 32'b0001);

    // Single timeout on cond1
    lat[0] = 1; lat[1] = 0; lat[2] = 1; lat[3] = 1;
    pulse_start();
    run(0, -1);
    check("to1_done_seen", 32'(done_seen), 32'd1);
    check("to1_tflag", 32'(timeout_flag), 32'b0010);
    check("to1_t0", t_cond0, 32'd8);
    check("to1_t1", t_cond1, TIMER_MAX);
    check("to1_t2", t_cond2, 32'd8);
    check("to1_t3", t_cond3, 32'd8);
    check("to1_led", 32'(led_onehot), 32'b0001);

    // All conditions time out
    lat[0] = 0; lat[1] = 0; lat[2] = 0; lat[3] = 0;
    pulse_start();
    run(0, -1);
    check("toall_done_seen", 32'(done_seen), 32'd1);
    check("toall_total_cycles", 32'(done_iter), 32'd76);
    check("toall_tflag", 32'(timeout_flag), 32'hF);
    check("toall_led", 32'(led_onehot), 32'd0);
    check("toall_done", 32'(done), 32'd1);
    check("toall_t2", t_cond2, TIMER_MAX);

    // Reset during cond2 WAIT, then a stray job_done
    lat[0] = 3; lat[1] = 3; lat[2] = 3; lat[3] = 3;
    pulse_start();
    run(0, 2);
    check("rst_pre_cond", 32'(cond_sel), 32'd2);
    check("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    job_done = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cond_sel", 32'(cond_sel), 32'd0);
    check("rst_t0", t_cond0, 32'd0);
    check("rst_t1", t_cond1, 32'd0);
    check("rst_tflag", 32'(timeout_flag), 32'd0);
    @(negedge sysclk);
    job_done = 1'b0;
    repeat (3) @(negedge sysclk);
    check("rst_idle_busy", 32'(busy), 32'd0);
    check("rst_idle_job_start", 32'(job_start), 32'd0);
    check("rst_idle_job_id", 32'(job_id), 32'd0);
    check("rst_idle_t0", t_cond0, 32'd0);
    check("rst_idle_done", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
